// File: rtl/key_led_pkg.sv
// Shared types and constants for the key-driven LED sequencer.
// The LONG_PRESS_EN build option is handled in key_debounce and key_led_sched.
package key_led_pkg;

    localparam int unsigned NUM_KEY = 2;
    localparam int unsigned NUM_LED = 4;

    typedef enum logic [1:0] {
        MODE_BLINK     = 2'd0,
        MODE_CHASE_FWD = 2'd1,
        MODE_CHASE_REV = 2'd2
    } mode_e;

    localparam logic [NUM_LED-1:0] LED_ALL_ON  = 4'hF;
    localparam logic [NUM_LED-1:0] LED_ALL_OFF = 4'h0;

    function automatic logic [NUM_LED-1:0] led_pattern(input mode_e m, input logic [1:0] step);
        logic [NUM_LED-1:0] pat;
        pat = LED_ALL_OFF;
        case (m)
            MODE_BLINK:     pat = step[0] ? LED_ALL_ON : LED_ALL_OFF;
            MODE_CHASE_FWD: pat = 4'b0001 << step;
            MODE_CHASE_REV: pat = 4'b1000 >> step;
            default:        pat = LED_ALL_OFF;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// One push-button: 2-FF synchroniser, debounce counter and press pulse.
// With LONG_PRESS_EN defined, also a saturating long-press counter and pulse.
module key_debounce #(
    parameter int unsigned DEBOUNCE_W = 14,
    parameter int unsigned LP_W       = 27
) (
    input  logic clk_50m,
    input  logic rst,
    input  logic key_raw,
    output logic press_evt,
    output logic long_press
);

    localparam logic [DEBOUNCE_W-1:0] DB_LIMIT = DEBOUNCE_W'((1 << (DEBOUNCE_W-1)) - 1);

    logic                  sync1_q, sync2_q;
    logic                  deb_q, deb_d;
    logic                  deb_dly_q;
    logic                  evt_q, evt_d;
    logic [DEBOUNCE_W-1:0] cnt_q, cnt_d;

    always_comb begin
        deb_d = deb_q;
        cnt_d = '0;
        if (sync2_q != deb_q) begin
            if (cnt_q == DB_LIMIT) begin
                deb_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        // Rise seen one cycle late so the pulse trails the debounced edge.
        evt_d = deb_q & ~deb_dly_q;
    end

    always_ff @(posedge clk_50m or posedge rst) begin
        if (rst) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            deb_q     <= 1'b0;
            deb_dly_q <= 1'b0;
            cnt_q     <= '0;
            evt_q     <= 1'b0;
        end else begin
            sync1_q   <= key_raw;
            sync2_q   <= sync1_q;
            deb_q     <= deb_d;
            deb_dly_q <= deb_q;
            cnt_q     <= cnt_d;
            evt_q     <= evt_d;
        end
    end

    assign press_evt = evt_q;

`ifdef LONG_PRESS_EN
    localparam logic [LP_W-1:0] LP_MAX = '1;

    logic [LP_W-1:0] lp_cnt_q, lp_cnt_d;
    logic            lp_q, lp_d;

    always_comb begin
        lp_cnt_d = '0;
        lp_d     = 1'b0;
        if (deb_q) begin
            lp_cnt_d = (lp_cnt_q == LP_MAX) ? lp_cnt_q : lp_cnt_q + 1'b1;
            lp_d     = (lp_cnt_q == LP_MAX - 1'b1);
        end
    end

    always_ff @(posedge clk_50m or posedge rst) begin
        if (rst) begin
            lp_cnt_q <= '0;
            lp_q     <= 1'b0;
        end else begin
            lp_cnt_q <= lp_cnt_d;
            lp_q     <= lp_d;
        end
    end

    assign long_press = lp_q;
`else
    assign long_press = 1'b0;
`endif

endmodule

// File: rtl/key_led_sched.sv
// Debounced keys select an LED mode; a prescaler steps the 4-LED pattern.
// Build option LONG_PRESS_EN: a long hold of any key forces BLINK.
module key_led_sched
    import key_led_pkg::*;
#(
    parameter int unsigned DEBOUNCE_W = 14,
    parameter int unsigned STEP_W     = 26,
    parameter int unsigned LP_W       = 27
) (
    input  logic               clk_50m,
    input  logic               rst,
    input  logic [NUM_KEY-1:0] key,
    output logic [NUM_LED-1:0] led_out,
    output logic [1:0]         mode,
    output logic [NUM_KEY-1:0] press_evt,
    output logic               long_press
);

    logic [NUM_KEY-1:0] evt_vec;
    logic [NUM_KEY-1:0] lp_vec;

    for (genvar i = 0; i < NUM_KEY; i++) begin : g_key
        key_debounce #(
            .DEBOUNCE_W(DEBOUNCE_W),
            .LP_W      (LP_W)
        ) u_deb (
            .clk_50m   (clk_50m),
            .rst       (rst),
            .key_raw   (key[i]),
            .press_evt (evt_vec[i]),
            .long_press(lp_vec[i])
        );
    end

    mode_e               mode_q, mode_d;
    logic [STEP_W-1:0]   pre_q, pre_d;
    logic [1:0]          step_q, step_d;
    logic [NUM_LED-1:0]  led_q, led_d;
    logic                restart;

    always_comb begin
        mode_d  = mode_q;
        restart = 1'b0;
        // Long press outranks presses; key0 outranks key1.
        if (|lp_vec) begin
            mode_d  = MODE_BLINK;
            restart = 1'b1;
        end else if (evt_vec[0]) begin
            mode_d  = (mode_q == MODE_CHASE_FWD) ? MODE_BLINK : MODE_CHASE_FWD;
            restart = 1'b1;
        end else if (evt_vec[1]) begin
            mode_d  = (mode_q == MODE_CHASE_REV) ? MODE_BLINK : MODE_CHASE_REV;
            restart = 1'b1;
        end

        pre_d  = pre_q + 1'b1;
        step_d = (pre_q == '1) ? step_q + 2'd1 : step_q;
        if (restart) begin
            pre_d  = '0;
            step_d = '0;
        end

        led_d = led_pattern(mode_q, step_q);
    end

    always_ff @(posedge clk_50m or posedge rst) begin
        if (rst) begin
            mode_q <= MODE_BLINK;
            pre_q  <= '0;
            step_q <= '0;
            led_q  <= LED_ALL_OFF;
        end else begin
            mode_q <= mode_d;
            pre_q  <= pre_d;
            step_q <= step_d;
            led_q  <= led_d;
        end
    end

    assign led_out    = led_q;
    assign mode       = mode_q;
    assign press_evt  = evt_vec;
    assign long_press = |lp_vec;

endmodule

// File: tb/tb_key_led_sched.sv
// Directed self-checking bench for key_led_sched (DEBOUNCE_W=4, STEP_W=3, LP_W=6).
// The long-press scenario runs only when LONG_PRESS_EN is defined.
module tb_key_led_sched;

    logic       clk_50m = 1'b0;
    logic       rst     = 1'b1;
    logic [1:0] key     = 2'b00;
    logic [3:0] led_out;
    logic [1:0] mode;
    logic [1:0] press_evt;
    logic       long_press;

    int checks = 0;
    int errors = 0;

    key_led_sched #(
        .DEBOUNCE_W(4),
        .STEP_W    (3),
        .LP_W      (6)
    ) dut (
        .clk_50m   (clk_50m),
        .rst       (rst),
        .key       (key),
        .led_out   (led_out),
        .mode      (mode),
        .press_evt (press_evt),
        .long_press(long_press)
    );

    always #5 clk_50m = ~clk_50m;

    task automatic step_clk();
        @(posedge clk_50m);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        key = 2'b00;
        repeat (3) step_clk();
        checks++;
        if (led_out !== 4'b0000) begin errors++; $display("FAIL reset_led got %b exp %b", led_out, 4'b0000); end
        checks++;
        if (mode !== 2'd0) begin errors++; $display("FAIL reset_mode got %0d exp %0d", mode, 0); end
        checks++;
        if (press_evt !== 2'b00) begin errors++; $display("FAIL reset_evt got %b exp %b", press_evt, 2'b00); end
        checks++;
        if (long_press !== 1'b0) begin errors++; $display("FAIL reset_lp got %b exp %b", long_press, 1'b0); end
        rst = 1'b0;
    endtask

    task automatic test_blink();
        logic [3:0] exp_led;
        for (int e = 1; e <= 40; e++) begin
            step_clk();
            exp_led = ((((e - 1) / 8) % 2) == 1) ? 4'b1111 : 4'b0000;
            checks++;
            if (led_out !== exp_led) begin
                errors++;
                $display("FAIL blink_led edge %0d got %b exp %b", e, led_out, exp_led);
            end
        end
        checks++;
        if (mode !== 2'd0) begin errors++; $display("FAIL blink_mode got %0d exp %0d", mode, 0); end
    endtask

    task automatic test_chase_fwd();
        logic [3:0] exp_led;
        logic [1:0] exp_evt;
        key[0] = 1'b1;
        for (int e = 1; e <= 52; e++) begin
            step_clk();
            if (e <= 12) begin
                exp_evt = (e == 11) ? 2'b01 : 2'b00;
                checks++;
                if (press_evt !== exp_evt) begin
                    errors++;
                    $display("FAIL fwd_evt edge %0d got %b exp %b", e, press_evt, exp_evt);
                end
            end
            if (e == 11) begin
                checks++;
                if (mode !== 2'd0) begin errors++; $display("FAIL fwd_mode_early got %0d exp %0d", mode, 0); end
            end
            if (e == 12) begin
                checks++;
                if (mode !== 2'd1) begin errors++; $display("FAIL fwd_mode got %0d exp %0d", mode, 1); end
            end
            if (e >= 13) begin
                exp_led = 4'b0001 << (((e - 13) / 8) % 4);
                checks++;
                if (led_out !== exp_led) begin
                    errors++;
                    $display("FAIL fwd_led edge %0d got %b exp %b", e, led_out, exp_led);
                end
            end
        end
        key[0] = 1'b0;
        for (int e = 1; e <= 20; e++) begin
            step_clk();
            checks++;
            if (press_evt !== 2'b00) begin
                errors++;
                $display("FAIL release_evt edge %0d got %b exp %b", e, press_evt, 2'b00);
            end
        end
        checks++;
        if (mode !== 2'd1) begin errors++; $display("FAIL release_mode got %0d exp %0d", mode, 1); end
    endtask

    task automatic test_glitch();
        for (int g = 0; g < 3; g++) begin
            key[0] = 1'b1;
            for (int e = 0; e < 5; e++) begin
                step_clk();
                checks++;
                if (press_evt !== 2'b00) begin errors++; $display("FAIL glitch_evt got %b exp %b", press_evt, 2'b00); end
            end
            key[0] = 1'b0;
            for (int e = 0; e < 10; e++) begin
                step_clk();
                checks++;
                if (press_evt !== 2'b00) begin errors++; $display("FAIL glitch_evt got %b exp %b", press_evt, 2'b00); end
            end
        end
        checks++;
        if (mode !== 2'd1) begin errors++; $display("FAIL glitch_mode got %0d exp %0d", mode, 1); end
    endtask

    task automatic test_both_keys();
        key[0] = 1'b1;
        repeat (12) step_clk();
        checks++;
        if (mode !== 2'd0) begin errors++; $display("FAIL toggle_blink_mode got %0d exp %0d", mode, 0); end
        key = 2'b00;
        repeat (15) step_clk();
        key = 2'b11;
        for (int e = 1; e <= 12; e++) begin
            step_clk();
            if (e == 11) begin
                checks++;
                if (press_evt !== 2'b11) begin errors++; $display("FAIL both_evt got %b exp %b", press_evt, 2'b11); end
            end
            if (e == 12) begin
                checks++;
                if (mode !== 2'd1) begin errors++; $display("FAIL both_mode got %0d exp %0d", mode, 1); end
            end
        end
        key = 2'b00;
        repeat (15) step_clk();
        checks++;
        if (mode !== 2'd1) begin errors++; $display("FAIL both_mode_after got %0d exp %0d", mode, 1); end
    endtask

    task automatic test_rev_toggle_reset();
        key[1] = 1'b1;
        repeat (12) step_clk();
        checks++;
        if (mode !== 2'd2) begin errors++; $display("FAIL rev_mode got %0d exp %0d", mode, 2); end
        step_clk();
        checks++;
        if (led_out !== 4'b1000) begin errors++; $display("FAIL rev_led got %b exp %b", led_out, 4'b1000); end
        key[1] = 1'b0;
        repeat (15) step_clk();
        key[1] = 1'b1;
        for (int e = 1; e <= 23; e++) begin
            step_clk();
            if (e == 12) begin
                checks++;
                if (mode !== 2'd0) begin errors++; $display("FAIL rev_toggle_mode got %0d exp %0d", mode, 0); end
                key[1] = 1'b0;
            end
            if (e == 13 || e == 20) begin
                checks++;
                if (led_out !== 4'b0000) begin errors++; $display("FAIL rev_toggle_led edge %0d got %b exp %b", e, led_out, 4'b0000); end
            end
            if (e == 21) begin
                checks++;
                if (led_out !== 4'b1111) begin errors++; $display("FAIL rev_toggle_led edge %0d got %b exp %b", e, led_out, 4'b1111); end
            end
        end
        rst = 1'b1;
        #1;
        checks++;
        if (led_out !== 4'b0000) begin errors++; $display("FAIL async_reset_led got %b exp %b", led_out, 4'b0000); end
        checks++;
        if (mode !== 2'd0) begin errors++; $display("FAIL async_reset_mode got %0d exp %0d", mode, 0); end
    endtask

    task automatic test_held_through_reset();
        key[0] = 1'b1;
        repeat (2) step_clk();
        rst = 1'b0;
        for (int e = 1; e <= 12; e++) begin
            step_clk();
            if (e == 10 || e == 11) begin
                checks++;
                if (press_evt !== ((e == 11) ? 2'b01 : 2'b00)) begin
                    errors++;
                    $display("FAIL held_evt edge %0d got %b exp %b", e, press_evt, (e == 11) ? 2'b01 : 2'b00);
                end
            end
            if (e == 12) begin
                checks++;
                if (mode !== 2'd1) begin errors++; $display("FAIL held_mode got %0d exp %0d", mode, 1); end
            end
        end
        key[0] = 1'b0;
        repeat (15) step_clk();
        checks++;
        if (long_press !== 1'b0) begin errors++; $display("FAIL held_lp got %b exp %b", long_press, 1'b0); end
    endtask

`ifdef LONG_PRESS_EN
    task automatic test_long_press();
        key[1] = 1'b1;
        repeat (12) step_clk();
        checks++;
        if (mode !== 2'd2) begin errors++; $display("FAIL lp_setup_mode got %0d exp %0d", mode, 2); end
        key[1] = 1'b0;
        repeat (15) step_clk();
        key[0] = 1'b1;
        for (int e = 1; e <= 80; e++) begin
            step_clk();
            checks++;
            if (long_press !== (e == 73)) begin
                errors++;
                $display("FAIL lp_pulse edge %0d got %b exp %b", e, long_press, (e == 73));
            end
            if (e == 12 || e == 73) begin
                checks++;
                if (mode !== 2'd1) begin errors++; $display("FAIL lp_mode edge %0d got %0d exp %0d", e, mode, 1); end
            end
            if (e == 74 || e == 80) begin
                checks++;
                if (mode !== 2'd0) begin errors++; $display("FAIL lp_mode edge %0d got %0d exp %0d", e, mode, 0); end
            end
        end
        key[0] = 1'b0;
        repeat (15) step_clk();
    endtask
`endif

    initial begin
        test_reset();
        test_blink();
        test_chase_fwd();
        test_glitch();
        test_both_keys();
        test_rev_toggle_reset();
        test_held_through_reset();
`ifdef LONG_PRESS_EN
        test_long_press();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
